usb_rx_field_ctrl: RTL and testbench

USB 2.0 full-speed receive field sequencer, placed directly after the NRZI decoder. It consumes the decoded bit stream and the line SE0 indication, then performs the following:
- detects SYNC and removes stuffed bits;
- decodes the PID and sequences the packet fields (PID, address, endpoint, CRC5, frame number, data, EOP);
- drives the one-hot field qualifiers that the downstream stages (CRC checkers, address match, data sink) consume, and flags protocol errors.

---
 rtl/usb_rx_field_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_usb_rx_field_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_field_ctrl.sv
// -----------------------------------------------------------------------------
// usb_rx_field_ctrl
// USB 2.0 full-speed receive field sequencer, sitting right after the NRZI
// decoder. It finds SYNC, strips stuffed bits, decodes the PID and walks the
// packet fields, driving one-hot field qualifiers for the downstream CRC,
// address-match and data-sink stages.
//
// Parameters:
//   SYNC_MIN          minimum decoded zeros before the SYNC-ending 1 (3..7)
//
// Optional feature (compile-time macro):
//   USB_RX_PID_CHECK_EN  when defined, PID bits [7:4] must equal ~[3:0];
//                        a mismatch sends the packet to the error state.
//                        When undefined, decode uses PID bits [3:0] only.
//
// Ports:
//   gclk               in   12 MHz clock
//   reset_l            in   asynchronous active-low reset
//   rx_data_valid      in   decoded bit valid
//   rx_data            in   decoded bit
//   line_se0           in   SE0 on the bus (synchronous to gclk)
//   field_bit          out  de-stuffed bit (registered)
//   field_bit_valid    out  field_bit valid this cycle
//   idle_or_sync .. error  out  one-hot field qualifiers
//   pid_code           out  PID of current packet, first received bit in [0]
//   pkt_done           out  one-cycle pulse at the end of a good packet
// -----------------------------------------------------------------------------
module usb_rx_field_ctrl #(
    parameter int SYNC_MIN = 6
) (
    input  logic       gclk,
    input  logic       reset_l,
    input  logic       rx_data_valid,
    input  logic       rx_data,
    input  logic       line_se0,
    output logic       field_bit,
    output logic       field_bit_valid,
    output logic       idle_or_sync,
    output logic       pid,
    output logic       dev_address,
    output logic       end_point_address,
    output logic       crc5,
    output logic       frame_number,
    output logic       data_crc_eop,
    output logic       eop,
    output logic       error,
    output logic [3:0] pid_code,
    output logic       pkt_done
);

    typedef enum logic [3:0] {
        ST_IDLE_SYNC = 4'd0,
        ST_PID       = 4'd1,
        ST_ADDR      = 4'd2,
        ST_ENDP      = 4'd3,
        ST_CRC5      = 4'd4,
        ST_FRAME     = 4'd5,
        ST_DATA      = 4'd6,
        ST_EOP_WAIT  = 4'd7,
        ST_EOP       = 4'd8,
        ST_ERR       = 4'd9
    } state_e;

    // Bit positions inside the qualifier vector
    localparam int Q_IDLE  = 0;
    localparam int Q_PID   = 1;
    localparam int Q_ADDR  = 2;
    localparam int Q_ENDP  = 3;
    localparam int Q_CRC5  = 4;
    localparam int Q_FRAME = 5;
    localparam int Q_DATA  = 6;
    localparam int Q_EOP   = 7;
    localparam int Q_ERR   = 8;

    localparam logic [2:0] SYNC_MIN_C = 3'(SYNC_MIN);

    state_e      state_q, state_d;
    state_e      pid_next_s;
    logic [2:0]  zero_run_q, zero_run_d;
    logic [2:0]  ones_cnt_q, ones_cnt_d;
    logic [3:0]  field_cnt_q, field_cnt_d;
    logic [6:0]  pid_sr_q, pid_sr_d;
    logic [3:0]  pid_code_q, pid_code_d;
    logic        pid_ok_s;
    logic        stuff_s;
    logic        emit_s;
    logic        pkt_done_s;
    logic        field_bit_q, field_bit_d;
    logic        field_bit_valid_q;
    logic [8:0]  qual_q, qual_d;
    logic        pkt_done_q;

    // One-hot qualifier that a given state stands for
    function automatic logic [8:0] state_qual(input state_e s);
        logic [8:0] q;
        q = 9'd0;
        case (s)
            ST_IDLE_SYNC: q[Q_IDLE]  = 1'b1;
            ST_PID:       q[Q_PID]   = 1'b1;
            ST_ADDR:      q[Q_ADDR]  = 1'b1;
            ST_ENDP:      q[Q_ENDP]  = 1'b1;
            ST_CRC5:      q[Q_CRC5]  = 1'b1;
            ST_FRAME:     q[Q_FRAME] = 1'b1;
            ST_DATA:      q[Q_DATA]  = 1'b1;
            ST_EOP_WAIT:  q[Q_EOP]   = 1'b1;
            ST_EOP:       q[Q_EOP]   = 1'b1;
            default:      q[Q_ERR]   = 1'b1;
        endcase
        return q;
    endfunction

    // Index of the last bit of each fixed-length field
    function automatic logic [3:0] field_last(input state_e s);
        logic [3:0] n;
        case (s)
            ST_PID:   n = 4'd7;
            ST_ADDR:  n = 4'd6;
            ST_ENDP:  n = 4'd3;
            ST_CRC5:  n = 4'd4;
            ST_FRAME: n = 4'd10;
            default:  n = 4'd0;
        endcase
        return n;
    endfunction

    // PID decode, evaluated on the cycle the 8th PID bit arrives.
    // pid_sr_q then holds PID bits 0..6 and rx_data is bit 7.
    always_comb begin
`ifdef USB_RX_PID_CHECK_EN
        pid_ok_s = ({rx_data, pid_sr_q[6:4]} == ~pid_sr_q[3:0]);
`else
        pid_ok_s = 1'b1;
`endif
        if (!pid_ok_s) begin
            pid_next_s = ST_ERR;
        end else begin
            case (pid_sr_q[3:0])
                4'b0001, 4'b1001, 4'b1101: pid_next_s = ST_ADDR;
                4'b0101:                   pid_next_s = ST_FRAME;
                4'b0011, 4'b1011:          pid_next_s = ST_DATA;
                4'b0010, 4'b1010, 4'b1110: pid_next_s = ST_EOP_WAIT;
                default:                   pid_next_s = ST_ERR;
            endcase
        end
    end

    // Next-state and counter update logic
    always_comb begin
        state_d     = state_q;
        zero_run_d  = zero_run_q;
        ones_cnt_d  = ones_cnt_q;
        field_cnt_d = field_cnt_q;
        pid_sr_d    = pid_sr_q;
        pid_code_d  = pid_code_q;
        emit_s      = 1'b0;
        pkt_done_s  = 1'b0;
        // After six consecutive 1s the next consumed bit is a stuff bit
        stuff_s     = (ones_cnt_q == 3'd6);

        case (state_q)
            ST_IDLE_SYNC: begin
                // SE0 is ignored while hunting for SYNC
                if (rx_data_valid) begin
                    if (!rx_data) begin
                        if (zero_run_q != 3'd7) begin
                            zero_run_d = zero_run_q + 3'd1;
                        end else begin
                            zero_run_d = zero_run_q;
                        end
                    end else begin
                        zero_run_d = 3'd0;
                        if (zero_run_q >= SYNC_MIN_C) begin
                            state_d     = ST_PID;
                            ones_cnt_d  = 3'd1;
                            field_cnt_d = 4'd0;
                        end else begin
                            state_d = ST_IDLE_SYNC;
                        end
                    end
                end else begin
                    zero_run_d = zero_run_q;
                end
            end

            ST_PID, ST_ADDR, ST_ENDP, ST_CRC5, ST_FRAME: begin
                if (line_se0) begin
                    state_d = ST_ERR;
                end else if (!rx_data_valid) begin
                    state_d = ST_ERR;
                end else if (stuff_s) begin
                    if (rx_data) begin
                        state_d = ST_ERR;
                    end else begin
                        ones_cnt_d = 3'd0;
                    end
                end else begin
                    emit_s     = 1'b1;
                    ones_cnt_d = rx_data ? (ones_cnt_q + 3'd1) : 3'd0;
                    if (state_q == ST_PID) begin
                        pid_sr_d = {rx_data, pid_sr_q[6:1]};
                    end else begin
                        pid_sr_d = pid_sr_q;
                    end
                    if (field_cnt_q == field_last(state_q)) begin
                        field_cnt_d = 4'd0;
                        case (state_q)
                            ST_PID: begin
                                state_d    = pid_next_s;
                                pid_code_d = pid_sr_q[3:0];
                            end
                            ST_ADDR:  state_d = ST_ENDP;
                            ST_ENDP:  state_d = ST_CRC5;
                            ST_FRAME: state_d = ST_CRC5;
                            ST_CRC5:  state_d = ST_EOP_WAIT;
                            default:  state_d = ST_ERR;
                        endcase
                    end else begin
                        field_cnt_d = field_cnt_q + 4'd1;
                    end
                end
            end

            ST_DATA: begin
                if (line_se0) begin
                    state_d = ST_EOP;
                end else if (!rx_data_valid) begin
                    state_d = ST_ERR;
                end else if (stuff_s) begin
                    if (rx_data) begin
                        state_d = ST_ERR;
                    end else begin
                        ones_cnt_d = 3'd0;
                    end
                end else begin
                    emit_s     = 1'b1;
                    ones_cnt_d = rx_data ? (ones_cnt_q + 3'd1) : 3'd0;
                end
            end

            ST_EOP_WAIT: begin
                // Only a dropped stuff 0 may still arrive before SE0
                if (line_se0) begin
                    state_d = ST_EOP;
                end else if (!rx_data_valid) begin
                    state_d = ST_ERR;
                end else if (stuff_s && !rx_data) begin
                    ones_cnt_d = 3'd0;
                end else begin
                    state_d = ST_ERR;
                end
            end

            ST_EOP: begin
                if (!line_se0) begin
                    state_d     = ST_IDLE_SYNC;
                    pkt_done_s  = 1'b1;
                    ones_cnt_d  = 3'd0;
                    zero_run_d  = 3'd0;
                    field_cnt_d = 4'd0;
                end else begin
                    state_d = ST_EOP;
                end
            end

            ST_ERR: begin
                if (!rx_data_valid && !line_se0) begin
                    state_d     = ST_IDLE_SYNC;
                    ones_cnt_d  = 3'd0;
                    zero_run_d  = 3'd0;
                    field_cnt_d = 4'd0;
                end else begin
                    state_d = ST_ERR;
                end
            end

            default: begin
                state_d = ST_ERR;
            end
        endcase
    end

    // Output next-state: emitted bits carry the tag of the field they belong
    // to (the state they were consumed in); otherwise tag the new state.
    always_comb begin
        if (emit_s) begin
            field_bit_d = rx_data;
            qual_d      = state_qual(state_q);
        end else begin
            field_bit_d = field_bit_q;
            qual_d      = state_qual(state_d);
        end
    end

    // State register
    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ST_IDLE_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters and PID capture
    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            zero_run_q  <= 3'd0;
            ones_cnt_q  <= 3'd0;
            field_cnt_q <= 4'd0;
            pid_sr_q    <= 7'd0;
            pid_code_q  <= 4'd0;
        end else begin
            zero_run_q  <= zero_run_d;
            ones_cnt_q  <= ones_cnt_d;
            field_cnt_q <= field_cnt_d;
            pid_sr_q    <= pid_sr_d;
            pid_code_q  <= pid_code_d;
        end
    end

    // Registered outputs
    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            field_bit_q       <= 1'b1;
            field_bit_valid_q <= 1'b0;
            qual_q            <= 9'b0_0000_0001;
            pkt_done_q        <= 1'b0;
        end else begin
            field_bit_q       <= field_bit_d;
            field_bit_valid_q <= emit_s;
            qual_q            <= qual_d;
            pkt_done_q        <= pkt_done_s;
        end
    end

    assign field_bit         = field_bit_q;
    assign field_bit_valid   = field_bit_valid_q;
    assign idle_or_sync      = qual_q[Q_IDLE];
    assign pid               = qual_q[Q_PID];
    assign dev_address       = qual_q[Q_ADDR];
    assign end_point_address = qual_q[Q_ENDP];
    assign crc5              = qual_q[Q_CRC5];
    assign frame_number      = qual_q[Q_FRAME];
    assign data_crc_eop      = qual_q[Q_DATA];
    assign eop               = qual_q[Q_EOP];
    assign error             = qual_q[Q_ERR];
    assign pid_code          = pid_code_q;
    assign pkt_done          = pkt_done_q;

endmodule

// File: tb/tb_usb_rx_field_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for usb_rx_field_ctrl. Bits are driven one per clock and
// outputs are observed 1 time unit after each rising edge. A small monitor
// tallies emitted bits per qualifier tag so whole packets can be checked
// against hand-computed field values.
// -----------------------------------------------------------------------------
module tb_usb_rx_field_ctrl;

    logic       gclk;
    logic       reset_l;
    logic       rx_data_valid;
    logic       rx_data;
    logic       line_se0;
    logic       field_bit;
    logic       field_bit_valid;
    logic       idle_or_sync, pid, dev_address, end_point_address, crc5;
    logic       frame_number, data_crc_eop, eop, error;
    logic [3:0] pid_code;
    logic       pkt_done;
    logic [8:0] qual_w;

    // Tag indices into the monitor arrays
    localparam int T_PID   = 1;
    localparam int T_ADDR  = 2;
    localparam int T_ENDP  = 3;
    localparam int T_CRC5  = 4;
    localparam int T_FRAME = 5;
    localparam int T_DATA  = 6;

    int          checks;
    int          failures;
    int          tag_cnt [9];
    logic [31:0] tag_cap [9];
    int          pkt_cnt;
    int          err_seen;
    int          onehot_bad;

    usb_rx_field_ctrl #(.SYNC_MIN(6)) dut (
        .gclk              (gclk),
        .reset_l           (reset_l),
        .rx_data_valid     (rx_data_valid),
        .rx_data           (rx_data),
        .line_se0          (line_se0),
        .field_bit         (field_bit),
        .field_bit_valid   (field_bit_valid),
        .idle_or_sync      (idle_or_sync),
        .pid               (pid),
        .dev_address       (dev_address),
        .end_point_address (end_point_address),
        .crc5              (crc5),
        .frame_number      (frame_number),
        .data_crc_eop      (data_crc_eop),
        .eop               (eop),
        .error             (error),
        .pid_code          (pid_code),
        .pkt_done          (pkt_done)
    );

    assign qual_w = {error, eop, data_crc_eop, frame_number, crc5,
                     end_point_address, dev_address, pid, idle_or_sync};

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        for (int t = 0; t < 9; t++) begin
            tag_cnt[t] = 0;
            tag_cap[t] = 32'd0;
        end
        pkt_cnt  = 0;
        err_seen = 0;
    endtask

    task automatic observe();
        if ($countones(qual_w) != 1) onehot_bad++;
        if (pkt_done) pkt_cnt++;
        if (error) err_seen++;
        if (field_bit_valid) begin
            for (int t = 0; t < 9; t++) begin
                if (qual_w[t]) begin
                    if (tag_cnt[t] < 32) tag_cap[t][tag_cnt[t]] = field_bit;
                    tag_cnt[t]++;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic d, input logic s);
        rx_data_valid = v;
        rx_data       = d;
        line_se0      = s;
        @(posedge gclk);
        #1;
        observe();
    endtask

    task automatic send_bits(input logic [31:0] val, input int n);
        for (int i = 0; i < n; i++) step(1'b1, val[i], 1'b0);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
    endtask

    task automatic end_packet();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        onehot_bad    = 0;
        reset_l       = 1'b0;
        rx_data_valid = 1'b0;
        rx_data       = 1'b0;
        line_se0      = 1'b0;
        clear_mon();

        // Reset values
        repeat (3) @(posedge gclk);
        #1;
        check_eq("rst_qual", 32'(qual_w), 32'h001);
        check_eq("rst_fbit", 32'(field_bit), 32'h1);
        check_eq("rst_fbv", 32'(field_bit_valid), 32'h0);
        check_eq("rst_pid_code", 32'(pid_code), 32'h0);
        check_eq("rst_pkt_done", 32'(pkt_done), 32'h0);
        reset_l = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Too-short SYNC (5 zeros) must not start a packet
        clear_mon();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        send_bits(32'hD2, 8);
        check_eq("short_sync_idle", 32'(qual_w), 32'h001);
        check_eq("short_sync_nopid", 32'(tag_cnt[T_PID]), 32'd0);
        step(1'b0, 1'b0, 1'b0);

        // ACK handshake
        clear_mon();
        send_sync();
        send_bits(32'hD2, 8);
        check_eq("ack_pid_code", 32'(pid_code), 32'h2);
        step(1'b0, 1'b0, 1'b1);
        check_eq("ack_eop_qual", 32'(eop), 32'h1);
        step(1'b0, 1'b0, 1'b1);
        check_eq("ack_no_early_done", 32'(pkt_done), 32'h0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("ack_done_pulse", 32'(pkt_done), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        check_eq("ack_done_single", 32'(pkt_done), 32'h0);
        check_eq("ack_pid_bits", 32'(tag_cnt[T_PID]), 32'd8);
        check_eq("ack_pid_cap", tag_cap[T_PID], 32'hD2);
        check_eq("ack_no_err", 32'(err_seen), 32'd0);
        check_eq("ack_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // IN token addr 0x05 endp 0x1
        clear_mon();
        send_sync();
        send_bits(32'h69, 8);
        send_bits(32'h05, 7);
        send_bits(32'h1, 4);
        send_bits(32'h0E, 5);
        end_packet();
        check_eq("in_pid_code", 32'(pid_code), 32'h9);
        check_eq("in_addr_cnt", 32'(tag_cnt[T_ADDR]), 32'd7);
        check_eq("in_addr_val", tag_cap[T_ADDR], 32'h05);
        check_eq("in_endp_cnt", 32'(tag_cnt[T_ENDP]), 32'd4);
        check_eq("in_endp_val", tag_cap[T_ENDP], 32'h1);
        check_eq("in_crc5_cnt", 32'(tag_cnt[T_CRC5]), 32'd5);
        check_eq("in_crc5_val", tag_cap[T_CRC5], 32'h0E);
        check_eq("in_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check_eq("in_no_err", 32'(err_seen), 32'd0);

        // DATA0 with payload 0xFF: stuff 0 after the 6th consecutive 1
        clear_mon();
        send_sync();
        send_bits(32'hC3, 8);
        send_bits(32'hF, 4);
        step(1'b1, 1'b0, 1'b0);
        check_eq("d0_stuff_dropped", 32'(field_bit_valid), 32'h0);
        check_eq("d0_stuff_qual", 32'(qual_w), 32'h040);
        send_bits(32'hF, 4);
        send_bits(32'h0, 16);
        end_packet();
        check_eq("d0_data_cnt", 32'(tag_cnt[T_DATA]), 32'd24);
        check_eq("d0_data_val", tag_cap[T_DATA], 32'h0000_00FF);
        check_eq("d0_no_err", 32'(err_seen), 32'd0);
        check_eq("d0_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // DATA1 with seven consecutive 1s
        clear_mon();
        send_sync();
        send_bits(32'h4B, 8);
        send_bits(32'h3F, 6);
        check_eq("d1_pre_err", 32'(error), 32'h0);
        step(1'b1, 1'b1, 1'b0);
        check_eq("d1_err", 32'(error), 32'h1);
        step(1'b1, 1'b0, 1'b0);
        check_eq("d1_err_hold_valid", 32'(error), 32'h1);
        step(1'b0, 1'b0, 1'b1);
        check_eq("d1_err_hold_se0", 32'(error), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        check_eq("d1_err_exit", 32'(qual_w), 32'h001);
        check_eq("d1_data_cnt", 32'(tag_cnt[T_DATA]), 32'd6);
        check_eq("d1_pid_code", 32'(pid_code), 32'hB);
        check_eq("d1_no_done", 32'(pkt_cnt), 32'd0);

        // SE0 after 3 address bits of an OUT token
        clear_mon();
        send_sync();
        send_bits(32'hE1, 8);
        send_bits(32'h5, 3);
        step(1'b0, 1'b0, 1'b1);
        check_eq("addr_se0_err", 32'(error), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        check_eq("addr_se0_exit", 32'(idle_or_sync), 32'h1);
        check_eq("addr_se0_cnt", 32'(tag_cnt[T_ADDR]), 32'd3);
        check_eq("addr_se0_no_done", 32'(pkt_cnt), 32'd0);

        // SOF, then one extra bit before SE0
        clear_mon();
        send_sync();
        send_bits(32'hA5, 8);
        send_bits(32'h2AA, 11);
        send_bits(32'h0A, 5);
        step(1'b1, 1'b0, 1'b0);
        check_eq("sof_extra_err", 32'(error), 32'h1);
        end_packet();
        check_eq("sof_frame_cnt", 32'(tag_cnt[T_FRAME]), 32'd11);
        check_eq("sof_frame_val", tag_cap[T_FRAME], 32'h2AA);
        check_eq("sof_no_done", 32'(pkt_cnt), 32'd0);

        // Gap in rx_data_valid in the middle of DATA
        clear_mon();
        send_sync();
        send_bits(32'hC3, 8);
        send_bits(32'h1, 2);
        step(1'b0, 1'b0, 1'b0);
        check_eq("gap_err", 32'(error), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        check_eq("gap_exit", 32'(idle_or_sync), 32'h1);

        // Reserved PID 0000
        clear_mon();
        send_sync();
        send_bits(32'hF0, 8);
        step(1'b0, 1'b0, 1'b1);
        check_eq("bad_pid_err", 32'(error), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        check_eq("bad_pid_exit", 32'(idle_or_sync), 32'h1);

        // IN code with non-complemented check bits (byte 0x09)
        clear_mon();
        send_sync();
        send_bits(32'h09, 8);
        send_bits(32'h05, 7);
        send_bits(32'h1, 4);
        send_bits(32'h0E, 5);
        end_packet();
`ifdef USB_RX_PID_CHECK_EN
        check_eq("pidchk_err", 32'(err_seen != 0), 32'h1);
        check_eq("pidchk_done", 32'(pkt_cnt), 32'd0);
`else
        check_eq("pidchk_err", 32'(err_seen != 0), 32'h0);
        check_eq("pidchk_done", 32'(pkt_cnt), 32'd1);
        check_eq("pidchk_addr", tag_cap[T_ADDR], 32'h05);
`endif

        // Reset asserted in the middle of a DATA0 packet
        clear_mon();
        send_sync();
        send_bits(32'hC3, 8);
        send_bits(32'h2, 2);
        rx_data_valid = 1'b0;
        reset_l       = 1'b0;
        #1;
        check_eq("midrst_qual", 32'(qual_w), 32'h001);
        check_eq("midrst_pid_code", 32'(pid_code), 32'h0);
        check_eq("midrst_fbv", 32'(field_bit_valid), 32'h0);
        check_eq("midrst_fbit", 32'(field_bit), 32'h1);
        @(posedge gclk);
        #1;
        reset_l = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("midrst_no_done", 32'(pkt_cnt), 32'd0);

        check_eq("onehot_violations", 32'(onehot_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
